// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: flags every occurrence of a programmable 1..PAT_W-bit
// pattern in an enable-qualified bit stream, with a saturating match counter.
module seq_pattern_detector #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seq,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             cnt_clr,
  output logic             tick,
  output logic [CNT_W-1:0] match_count
);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] len_clamp;
  logic             match;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i] = (i < 32'(len_q));
    end

    hist_shift = {hist_q[PAT_W-2:0], seq};
    fill_inc   = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;

    if (cfg_len == '0) begin
      len_clamp = LEN_W'(1);
    end else if (cfg_len > LEN_W'(PAT_W)) begin
      len_clamp = LEN_W'(PAT_W);
    end else begin
      len_clamp = cfg_len;
    end

    // Only bits below len_q take part; the fill check keeps stale/cleared history from matching.
    match = en && !cfg_load && (fill_inc >= len_q) &&
            ((hist_shift & mask) == (pat_q & mask));
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    tick_d = 1'b0;
    cnt_d  = cnt_q;

    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = len_clamp;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      hist_d = hist_shift;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
      tick_d = match;
    end

    if (cnt_clr) begin
      cnt_d = CNT_W'(match);
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q  <= '1;
      len_q  <= LEN_W'(PAT_W);
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tick        = tick_q;
  assign match_count = cnt_q;

endmodule
